// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: holds all stages in reset, then releases them in
// order, gated by a minimum spacing and each stage's ready acknowledge.
module rst_seq_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int HOLD_CYC   = 8,
  parameter int STAGE_DLY  = 4,
  parameter int TIMEOUT    = 64,
  localparam int SW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int CMAX = (HOLD_CYC > TIMEOUT) ? HOLD_CYC : TIMEOUT,
  localparam int CW   = $clog2(CMAX + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_soft_rst,
  input  logic [NUM_STAGES-1:0] i_stage_ack,
  output logic [NUM_STAGES-1:0] o_stage_rst_n,
  output logic                  o_all_ready,
  output logic                  o_timeout,
  output logic [SW-1:0]         o_err_stage,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [SW-1:0] k;
  logic          spaced;

  // One counter serves as hold_cnt in HOLD and dly_cnt in WAIT; it saturates.
  always_comb begin
    cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
    spaced  = (cnt_nxt >= CW'(STAGE_DLY));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_soft_rst) begin
      state         <= S_HOLD;
      cnt           <= '0;
      k             <= '0;
      o_stage_rst_n <= '0;
      o_all_ready   <= 1'b0;
      o_timeout     <= 1'b0;
      o_err_stage   <= '0;
      o_busy        <= 1'b1;
    end else begin
      case (state)
        S_HOLD: begin
          cnt <= cnt_nxt;
          if (cnt_nxt == CW'(HOLD_CYC)) begin
            state         <= S_WAIT;
            cnt           <= '0;
            k             <= '0;
            o_stage_rst_n <= {{(NUM_STAGES-1){1'b0}}, 1'b1};
          end
        end
        S_WAIT: begin
          cnt <= cnt_nxt;
          // Advance is checked first so an ack on the timeout edge still wins.
          if (spaced && i_stage_ack[k]) begin
            if (k == LAST) begin
              state       <= S_DONE;
              o_all_ready <= 1'b1;
              o_busy      <= 1'b0;
            end else begin
              o_stage_rst_n <= {o_stage_rst_n[NUM_STAGES-2:0], 1'b1};
              k             <= k + 1'b1;
              cnt           <= '0;
            end
          end else if (cnt_nxt >= CW'(TIMEOUT)) begin
            state         <= S_ERR;
            o_timeout     <= 1'b1;
            o_err_stage   <= k;
            o_stage_rst_n <= '0;
            o_busy        <= 1'b0;
          end
        end
        S_DONE: ;
        S_ERR:  ;
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl with default parameters; edge numbers
// restart at 1 on the first edge after reset or soft reset is released.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst;
  logic [3:0] ack;
  logic [3:0] stage_rst_n;
  logic       all_ready;
  logic       timeout;
  logic [1:0] err_stage;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  rst_seq_ctrl #(
    .NUM_STAGES(4),
    .HOLD_CYC  (8),
    .STAGE_DLY (4),
    .TIMEOUT   (64)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_soft_rst   (soft_rst),
    .i_stage_ack  (ack),
    .o_stage_rst_n(stage_rst_n),
    .o_all_ready  (all_ready),
    .o_timeout    (timeout),
    .o_err_stage  (err_stage),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge %0d got %0h exp %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_stage_rst_n"}, 32'(stage_rst_n), 32'h0);
    check({tag, "_all_ready"}, 32'(all_ready), 32'h0);
    check({tag, "_timeout"}, 32'(timeout), 32'h0);
    check({tag, "_err_stage"}, 32'(err_stage), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h1);
  endtask

  // Runs up to edge 'last', checking against the given release edges.
  // Ack bit low_bit is held low on every edge before high_edge.
  task automatic run_check(input int r0, input int r1, input int r2, input int r3,
                           input int done, input int last,
                           input int low_bit, input int high_edge);
    int r[4];
    logic [3:0] es;
    r = '{r0, r1, r2, r3};
    while (edge_n < last) begin
      ack = 4'hF;
      if (edge_n + 1 < high_edge) ack[low_bit] = 1'b0;
      step();
      for (int j = 0; j < 4; j++) es[j] = (edge_n >= r[j]);
      check("stage_rst_n", 32'(stage_rst_n), 32'(es));
      check("all_ready", 32'(all_ready), 32'(edge_n >= done));
      check("busy", 32'(busy), 32'(edge_n < done));
      check("timeout", 32'(timeout), 32'h0);
      check("err_stage", 32'(err_stage), 32'h0);
    end
  endtask

  task automatic soft_pulse(input string tag);
    soft_rst = 1'b1;
    step();
    check_cleared(tag);
    soft_rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic hard_reset(input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_cleared(tag);
    end
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    soft_rst = 1'b0;
    ack      = 4'hF;

    hard_reset("por");

    // Nominal sequence with all acks high.
    run_check(8, 12, 16, 20, 24, 24, 0, 0);

    // DONE ignores acks and holds its outputs.
    ack = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("done_stage_rst_n", 32'(stage_rst_n), 32'hF);
      check("done_all_ready", 32'(all_ready), 32'h1);
      check("done_busy", 32'(busy), 32'h0);
    end

    // Soft reset from DONE restarts the full sequence.
    soft_pulse("soft_done");
    run_check(8, 12, 16, 20, 24, 24, 0, 0);

    // Soft reset coincides with the final advance condition: soft reset wins.
    soft_pulse("soft_pre6");
    run_check(8, 12, 16, 20, 999, 23, 0, 0);
    ack = 4'hF;
    soft_pulse("soft_final");
    run_check(8, 12, 16, 20, 24, 24, 0, 0);

    // Hard reset while waiting on stage 1.
    soft_pulse("soft_pre5");
    run_check(8, 12, 999, 999, 999, 13, 0, 0);
    hard_reset("rst_wait");
    run_check(8, 12, 16, 20, 24, 24, 0, 0);

    // Late ack on stage 1 stretches the remaining releases.
    soft_pulse("soft_pre2");
    run_check(8, 12, 22, 26, 30, 30, 1, 22);

    // Stage 2 never acks: timeout at edge 80.
    soft_pulse("soft_pre3");
    run_check(8, 12, 16, 999, 999, 79, 2, 999);
    ack = 4'hB;
    step();
    check("to_timeout", 32'(timeout), 32'h1);
    check("to_err_stage", 32'(err_stage), 32'h2);
    check("to_stage_rst_n", 32'(stage_rst_n), 32'h0);
    check("to_busy", 32'(busy), 32'h0);
    check("to_all_ready", 32'(all_ready), 32'h0);
    ack = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("err_sticky_timeout", 32'(timeout), 32'h1);
      check("err_sticky_stage", 32'(err_stage), 32'h2);
      check("err_sticky_rst_n", 32'(stage_rst_n), 32'h0);
    end
    soft_pulse("soft_err");
    run_check(8, 12, 16, 20, 24, 24, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset release sequencer placed directly downstream of the bench/board clock-and-reset generator.
- Consumes the single global clock and its active-low reset.
- Releases NUM_STAGES per-stage resets one at a time, in order.
- Before releasing the next stage, waits for a minimum spacing and for the current stage's ready acknowledge.
- Flags a timeout if a stage never acknowledges, and supports a soft-reset request that restarts the whole sequence.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (>=2)
HOLD_CYC, 8, cycles all stages stay in reset after i_rst_n deasserts or a soft reset (>=1)
STAGE_DLY, 4, minimum edges between release of stage k and release of stage k+1 (>=1)
TIMEOUT, 64, edges after release of stage k without ack before error (TIMEOUT > STAGE_DLY)

Ports:
i_clk  input  1  single clock
i_rst_n  input  1  synchronous active-low reset
i_soft_rst  input  1  level-sampled request to restart the sequence
i_stage_ack  input  NUM_STAGES  per-stage ready; bit k is sampled only while waiting on stage k
o_stage_rst_n  output  NUM_STAGES  per-stage active-low reset; bit k released before bit k+1
o_all_ready  output  1  high in DONE
o_timeout  output  1  high in ERR
o_err_stage  output  max(1,$clog2(NUM_STAGES))  index of the stage that timed out
o_busy  output  1  high in HOLD or WAIT

Behaviour:
- Clocking and reset:
  - One clock domain, rising edge only.
  - i_rst_n is synchronous and active-low. Any edge sampling i_rst_n=0 forces:
    - state=HOLD, counters=0, stage index k=0
    - o_stage_rst_n=0, o_all_ready=0, o_timeout=0, o_err_stage=0, o_busy=1
  - i_rst_n=0 mid-sequence has the same effect; no partial state is kept.
- State machine: HOLD, WAIT, DONE, ERR. All outputs are registered.
- Edge counting: edges are numbered from the first edge sampling i_rst_n=1 (edge 1).
- HOLD:
  - hold_cnt increments each edge.
  - At the edge where hold_cnt reaches HOLD_CYC: o_stage_rst_n[0] <= 1, k=0, dly_cnt=0, state <= WAIT.
  - Result: stage 0 is released at edge HOLD_CYC.
- WAIT (stage k released):
  - dly_cnt increments each edge, so it equals 1 on the first edge after the release.
  - Advance condition: dly_cnt >= STAGE_DLY and i_stage_ack[k]=1 at the same edge.
  - On advance with k < NUM_STAGES-1: o_stage_rst_n[k+1] <= 1, k <= k+1, dly_cnt <= 0.
  - On advance with k = NUM_STAGES-1: state <= DONE, o_all_ready <= 1, o_busy <= 0.
  - Ack that is high before STAGE_DLY has elapsed is ignored until the spacing is met.
  - Timeout: dly_cnt = TIMEOUT with ack low at that edge -> state <= ERR, o_timeout <= 1, o_err_stage <= k, o_stage_rst_n <= 0 (all stages re-held), o_busy <= 0.
  - Ack high at the TIMEOUT edge counts as an advance, not an error.
- Released bits stay high until reset, soft reset or ERR. Bits above k are always 0.
- DONE: i_stage_ack is ignored; outputs are held.
- ERR: sticky until soft reset or i_rst_n.
- Soft reset:
  - i_soft_rst=1 at any edge with i_rst_n=1, in any state: next state HOLD, o_stage_rst_n=0, o_all_ready=0, o_timeout=0, o_err_stage=0, o_busy=1, counters cleared.
  - Stage 0 is released HOLD_CYC edges after the last edge sampling i_soft_rst=1.
  - Holding i_soft_rst high keeps the block in HOLD.
- Priority: i_rst_n > i_soft_rst > advance > timeout.
- Counter width: $clog2(max(HOLD_CYC,TIMEOUT)+1) bits; counters saturate and never wrap.

Test Plan:
1. Defaults, i_stage_ack tied all-ones, i_rst_n released -> o_stage_rst_n bits rise at edges 8/12/16/20, o_all_ready=1 at edge 24, o_busy=0 from edge 24, o_timeout stays 0.
2. Defaults; ack[1] low until 10 edges after stage-1 release (edge 22), other acks high -> stage 2 at edge 22, stage 3 at 26, o_all_ready at 30.
3. ack[2] held low -> stage 2 at edge 16; at edge 80: o_timeout=1, o_err_stage=2, o_stage_rst_n=4'b0000, o_busy=0; stays there until a soft reset pulse, then o_timeout=0 and the sequence restarts (stage 0 released 8 edges later).
4. One-cycle i_soft_rst in DONE -> next edge o_stage_rst_n=0, o_all_ready=0, o_busy=1; stage 0 at +8, o_all_ready at +24 with acks high.
5. i_rst_n pulled low for 3 edges while in WAIT on stage 1 -> all outputs at reset values on the first low edge; after release, identical timing to scenario 1 measured from the new release.
6. i_soft_rst high at the same edge as the final advance condition (k=3, dly_cnt=4, ack high) -> soft reset wins: o_all_ready stays 0, state HOLD.
